sys_spm_banked: RTL and testbench

Parametrised, multi-port, word-interleaved system scratchpad memory, succeeding the single-port sys_spm. NumPorts requesters share NumBanks banks, with a per-bank round-robin arbiter and a fixed 2-cycle response latency. It adds a hardware zero-fill init engine, optionally triggered automatically on reset, and a saturating bank-conflict counter. It sits between the system NoC target adapters and the SPM macros; banks are modelled as internal arrays.

---
 rtl/sys_spm_banked_pkg.sv | 30 +++
 rtl/sys_spm_rr_arb.sv | 60 ++++++
 rtl/sys_spm_banked.sv | 230 +++++++++++++++++++++++
 tb/tb_sys_spm_banked.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_spm_banked_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sys_spm_banked_pkg
// Brief    : Shared constants, init FSM encoding and helpers for the banked
//            system scratchpad.
// Revision : 1.0 - initial release
// ============================================================================
package sys_spm_banked_pkg;

    localparam int c_RSP_LATENCY      = 2;
    localparam int c_CNT_WIDTH        = 32;

    localparam int c_DEF_NUM_PORTS    = 2;
    localparam int c_DEF_NUM_BANKS    = 4;
    localparam int c_DEF_DATA_WIDTH   = 64;
    localparam int c_DEF_WORDS_PER_BK = 256;
    localparam int c_DEF_INIT_ON_RST  = 1;

    typedef enum logic [0:0] {
        INIT_IDLE = 1'b0,
        INIT_FILL = 1'b1
    } init_state_e;

    // Index width that never collapses to zero bits for degenerate sizes.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sys_spm_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : sys_spm_rr_arb
// Brief    : Round-robin arbiter, one-hot grant, pointer advances past winner.
// Revision : 1.0 - initial release
// ============================================================================
module sys_spm_rr_arb
    import sys_spm_banked_pkg::*;
#(
    parameter int NUM_PORTS = c_DEF_NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] i_req,
    output logic [NUM_PORTS-1:0] o_gnt
);

    localparam int PTR_W = clog2_min1(NUM_PORTS);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_winner;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic             w_found;

    // Two passes: requesters at/after the pointer first, then the wrap-around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && i_req[i] && (PTR_W'(i) >= r_ptr)) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!w_found && i_req[i]) begin
                w_found  = 1'b1;
                w_winner = PTR_W'(i);
            end
        end
        o_gnt = '0;
        if (w_found) begin
            o_gnt[w_winner] = 1'b1;
        end
        w_ptr_nxt = r_ptr;
        if (w_found) begin
            w_ptr_nxt = (w_winner == PTR_W'(NUM_PORTS - 1)) ? '0 : w_winner + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sys_spm_banked.sv
`default_nettype none
// ============================================================================
// Module   : sys_spm_banked
// Brief    : Multi-port word-interleaved scratchpad with per-bank round-robin
//            arbitration, 2-cycle responses, zero-fill engine and stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module sys_spm_banked
    import sys_spm_banked_pkg::*;
#(
    parameter int NUM_PORTS      = c_DEF_NUM_PORTS,
    parameter int NUM_BANKS      = c_DEF_NUM_BANKS,
    parameter int DATA_WIDTH     = c_DEF_DATA_WIDTH,
    parameter int WORDS_PER_BANK = c_DEF_WORDS_PER_BK,
    parameter int INIT_ON_RESET  = c_DEF_INIT_ON_RST,
    parameter int ADDR_WIDTH     = $clog2(NUM_BANKS * WORDS_PER_BANK)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_PORTS-1:0]                req_valid_i,
    output logic [NUM_PORTS-1:0]                req_ready_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [NUM_PORTS-1:0]                req_we_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_be_i,
    output logic [NUM_PORTS-1:0]                rsp_valid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]     rsp_rdata_o,
    input  logic                                init_start_i,
    output logic                                init_busy_o,
    input  logic                                cnt_clear_i,
    output logic [c_CNT_WIDTH-1:0]              conflict_cnt_o
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int BANK_W = clog2_min1(NUM_BANKS);
    localparam int ROW_W  = clog2_min1(WORDS_PER_BANK);

    // ------------------------------------------------------------------
    // Address decode and per-bank request matrix
    // ------------------------------------------------------------------
    logic [BANK_W-1:0]     w_port_bank [NUM_PORTS];
    logic [ROW_W-1:0]      w_port_row  [NUM_PORTS];
    logic [NUM_PORTS-1:0]  w_bank_req  [NUM_BANKS];
    logic [NUM_PORTS-1:0]  w_bank_gnt  [NUM_BANKS];
    logic                  w_busy;

    init_state_e           r_init_state;
    logic [ROW_W-1:0]      r_init_row;
    logic                  r_rst_seen;

    assign w_busy = (r_init_state == INIT_FILL);

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_port_bank[p] = BANK_W'(32'(req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]) % NUM_BANKS);
            w_port_row[p]  = ROW_W'(32'(req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH]) / NUM_BANKS);
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bank_req[b] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                w_bank_req[b][p] = req_valid_i[p] & ~w_busy & ~rst_i
                                 & (w_port_bank[p] == BANK_W'(b));
            end
        end
    end

    // A port targets exactly one bank, so OR-ing grants across banks is safe.
    always_comb begin
        req_ready_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            req_ready_o = req_ready_o | w_bank_gnt[b];
        end
    end

    // ------------------------------------------------------------------
    // Winner selection per bank
    // ------------------------------------------------------------------
    logic                  w_bank_act   [NUM_BANKS];
    logic                  w_bank_we    [NUM_BANKS];
    logic [ROW_W-1:0]      w_bank_row   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_bank_wdata [NUM_BANKS];
    logic [BE_W-1:0]       w_bank_be    [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bank_act[b]   = |w_bank_gnt[b];
            w_bank_we[b]    = 1'b0;
            w_bank_row[b]   = '0;
            w_bank_wdata[b] = '0;
            w_bank_be[b]    = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_bank_gnt[b][p]) begin
                    w_bank_we[b]    = req_we_i[p];
                    w_bank_row[b]   = w_port_row[p];
                    w_bank_wdata[b] = req_wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                    w_bank_be[b]    = req_be_i[p*BE_W +: BE_W];
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [WORDS_PER_BANK];

        sys_spm_rr_arb #(
            .NUM_PORTS (NUM_PORTS)
        ) u_arb (
            .clk   (clk_i),
            .rst   (rst_i),
            .i_req (w_bank_req[b]),
            .o_gnt (w_bank_gnt[b])
        );

        // Contents survive reset; only the fill engine or a granted write
        // changes them.
        always_ff @(posedge clk_i) begin
            if (w_busy) begin
                r_mem[r_init_row] <= '0;
            end else if (w_bank_act[b] && w_bank_we[b]) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (w_bank_be[b][i]) begin
                        r_mem[w_bank_row[b]][i*8 +: 8] <= w_bank_wdata[b][i*8 +: 8];
                    end
                end
            end
        end

        assign w_bank_rdata[b] = r_mem[w_bank_row[b]];
    end

    // ------------------------------------------------------------------
    // Response pipeline: stage 0 is the array sample, later stages delay
    // ------------------------------------------------------------------
    logic [NUM_PORTS*DATA_WIDTH-1:0] w_cap_data;
    logic [NUM_PORTS-1:0]            r_rsp_vld  [c_RSP_LATENCY];
    logic [NUM_PORTS*DATA_WIDTH-1:0] r_rsp_data [c_RSP_LATENCY];

    always_comb begin
        w_cap_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (req_ready_o[p] && !req_we_i[p]) begin
                w_cap_data[p*DATA_WIDTH +: DATA_WIDTH] = w_bank_rdata[w_port_bank[p]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < c_RSP_LATENCY; s++) begin
                r_rsp_vld[s]  <= '0;
                r_rsp_data[s] <= '0;
            end
        end else begin
            r_rsp_vld[0]  <= req_ready_o;
            r_rsp_data[0] <= w_cap_data;
            for (int s = 1; s < c_RSP_LATENCY; s++) begin
                r_rsp_vld[s]  <= r_rsp_vld[s-1];
                r_rsp_data[s] <= r_rsp_data[s-1];
            end
        end
    end

    assign rsp_valid_o = r_rsp_vld[c_RSP_LATENCY-1];
    assign rsp_rdata_o = r_rsp_data[c_RSP_LATENCY-1];

    // ------------------------------------------------------------------
    // Zero-fill engine
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_init_state <= INIT_IDLE;
            r_init_row   <= '0;
            r_rst_seen   <= 1'b1;
        end else begin
            r_rst_seen <= 1'b0;
            case (r_init_state)
                INIT_IDLE: begin
                    if (init_start_i || ((INIT_ON_RESET != 0) && r_rst_seen)) begin
                        r_init_state <= INIT_FILL;
                        r_init_row   <= '0;
                    end
                end
                INIT_FILL: begin
                    if (r_init_row == ROW_W'(WORDS_PER_BANK - 1)) begin
                        r_init_state <= INIT_IDLE;
                        r_init_row   <= '0;
                    end else begin
                        r_init_row <= r_init_row + 1'b1;
                    end
                end
                default: begin
                    r_init_state <= INIT_IDLE;
                end
            endcase
        end
    end

    assign init_busy_o = w_busy;

    // ------------------------------------------------------------------
    // Saturating stall counter
    // ------------------------------------------------------------------
    logic [c_CNT_WIDTH-1:0] r_cnt;
    logic [c_CNT_WIDTH-1:0] w_cnt_nxt;
    logic                   w_stall;

    assign w_stall = ~w_busy & (|(req_valid_i & ~req_ready_o));

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (cnt_clear_i) begin
            w_cnt_nxt = '0;
        end else if (w_stall && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign conflict_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sys_spm_banked.sv
`default_nettype none
// ============================================================================
// Module   : tb_sys_spm_banked
// Brief    : Directed self-checking bench with a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sys_spm_banked;

    localparam int NP  = 2;
    localparam int NB  = 4;
    localparam int DW  = 64;
    localparam int WPB = 16;
    localparam int AW  = 6;
    localparam int BEW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_ready;
    logic [NP*AW-1:0]  req_addr;
    logic [NP-1:0]     req_we;
    logic [NP*DW-1:0]  req_wdata;
    logic [NP*BEW-1:0] req_be;
    logic [NP-1:0]     rsp_valid;
    logic [NP*DW-1:0]  rsp_rdata;
    logic              init_start;
    logic              init_busy;
    logic              cnt_clear;
    logic [31:0]       cnt;

    int checks   = 0;
    int failures = 0;

    sys_spm_banked #(
        .NUM_PORTS      (NP),
        .NUM_BANKS      (NB),
        .DATA_WIDTH     (DW),
        .WORDS_PER_BANK (WPB),
        .INIT_ON_RESET  (1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_addr_i     (req_addr),
        .req_we_i       (req_we),
        .req_wdata_i    (req_wdata),
        .req_be_i       (req_be),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .init_start_i   (init_start),
        .init_busy_o    (init_busy),
        .cnt_clear_i    (cnt_clear),
        .conflict_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: flat word memory, per-bank RR pointers, response
    // schedule indexed by due cycle.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem [NB*WPB];
    int            m_ptr [NB];
    logic          m_busy;
    int            m_row;
    logic          m_after_rst;
    logic [31:0]   m_cnt;
    logic          slot_v [4][NP];
    logic [DW-1:0] slot_d [4][NP];
    int            cyc = 0;
    bit            started = 1'b0;
    logic [NP-1:0] e_ready;
    int            win [NB];
    int            pp, sl, a;

    task automatic model_reset();
        for (int b = 0; b < NB; b++) m_ptr[b] = 0;
        m_busy      = 1'b0;
        m_row       = 0;
        m_after_rst = 1'b1;
        m_cnt       = '0;
        for (int s = 0; s < 4; s++)
            for (int p = 0; p < NP; p++) begin
                slot_v[s][p] = 1'b0;
                slot_d[s][p] = '0;
            end
    endtask

    initial begin
        for (int i = 0; i < NB*WPB; i++) m_mem[i] = '0;
    end

    always @(negedge clk) begin
        if (!started) begin
            if (rst_i) begin
                started = 1'b1;
                model_reset();
            end
        end else begin
            e_ready = '0;
            for (int b = 0; b < NB; b++) win[b] = -1;
            if (!rst_i && !m_busy) begin
                for (int b = 0; b < NB; b++)
                    for (int k = 0; k < NP; k++) begin
                        pp = (m_ptr[b] + k) % NP;
                        if (win[b] < 0 && req_valid[pp] && (int'(req_addr[pp*AW +: AW]) % NB == b)) begin
                            win[b]      = pp;
                            e_ready[pp] = 1'b1;
                        end
                    end
            end
            sl = cyc % 4;
            check("ready", req_ready, e_ready);
            for (int p = 0; p < NP; p++) begin
                check("rsp_valid", rsp_valid[p], slot_v[sl][p]);
                if (slot_v[sl][p]) check("rsp_rdata", rsp_rdata[p*DW +: DW], slot_d[sl][p]);
            end
            check("init_busy", init_busy, m_busy);
            check("conflict_cnt", cnt, m_cnt);

            if (rst_i) begin
                model_reset();
            end else begin
                for (int p = 0; p < NP; p++) slot_v[sl][p] = 1'b0;
                for (int p = 0; p < NP; p++)
                    if (e_ready[p]) begin
                        a = int'(req_addr[p*AW +: AW]);
                        slot_v[(cyc + 2) % 4][p] = 1'b1;
                        slot_d[(cyc + 2) % 4][p] = req_we[p] ? '0 : m_mem[a];
                    end
                for (int p = 0; p < NP; p++)
                    if (e_ready[p] && req_we[p]) begin
                        a = int'(req_addr[p*AW +: AW]);
                        for (int i = 0; i < BEW; i++)
                            if (req_be[p*BEW + i]) m_mem[a][i*8 +: 8] = req_wdata[p*DW + i*8 +: 8];
                    end
                for (int b = 0; b < NB; b++)
                    if (win[b] >= 0) m_ptr[b] = (win[b] + 1) % NP;
                if (cnt_clear) m_cnt = '0;
                else if (!m_busy && ((req_valid & ~e_ready) != '0) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_busy) begin
                    for (int b = 0; b < NB; b++) m_mem[m_row*NB + b] = '0;
                    if (m_row == WPB - 1) m_busy = 1'b0;
                    else m_row = m_row + 1;
                end else if (init_start || m_after_rst) begin
                    m_busy = 1'b1;
                    m_row  = 0;
                end
                m_after_rst = 1'b0;
            end
            cyc++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic [AW-1:0] ad, input logic w,
                            input logic [DW-1:0] d, input logic [BEW-1:0] be);
        req_valid[p]            = v;
        req_addr[p*AW +: AW]    = ad;
        req_we[p]               = w;
        req_wdata[p*DW +: DW]   = d;
        req_be[p*BEW +: BEW]    = be;
    endtask

    // Single transfer; response must appear exactly two cycles after the grant.
    task automatic xfer(input int p, input logic [AW-1:0] ad, input logic w, input logic [DW-1:0] d,
                        input logic [BEW-1:0] be, input logic [DW-1:0] exp, input string name);
        bit g = 1'b0;
        set_port(p, 1'b1, ad, w, d, be);
        for (int n = 0; n < 20 && !g; n++) begin
            @(negedge clk);
            g = req_ready[p];
            tick();
        end
        set_port(p, 1'b0, ad, w, d, be);
        check({name, "_grant"}, g, 1);
        @(negedge clk);
        @(negedge clk);
        check({name, "_rsp_valid"}, rsp_valid[p], 1);
        check({name, "_rsp_data"}, rsp_rdata[p*DW +: DW], exp);
        tick();
    endtask

    task automatic count_busy(output int nb);
        bit seen = 1'b0;
        bit done = 1'b0;
        nb = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (init_busy) begin
                seen = 1'b1;
                nb++;
                check("busy_ready", req_ready, 0);
            end else if (seen) begin
                done = 1'b1;
            end
            tick();
        end
    endtask

    logic [1:0] exp_seq [4];
    int         nbusy;

    initial begin
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        rst_i = 1'b1; req_valid = '0; req_addr = '0; req_we = '0; req_wdata = '0; req_be = '0;
        init_start = 1'b0; cnt_clear = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", init_busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_cnt", cnt, 0);
        tick();
        rst_i = 1'b0;
        tick();
        // Requests held through the fill must stay stalled, then be served.
        set_port(0, 1'b1, 6'd0, 1'b0, '0, '0);
        set_port(1, 1'b1, 6'd1, 1'b0, '0, '0);
        count_busy(nbusy);
        req_valid = '0;
        check("init_len", nbusy, WPB);

        xfer(1, 6'h3F, 1'b0, '0, '0, 64'h0, "rd3f");

        // Write then read-after-write on the next cycle.
        set_port(0, 1'b1, 6'd5, 1'b1, 64'h1122_3344_5566_7788, 8'hFF);
        @(negedge clk);
        check("raw_wr_grant", req_ready[0], 1);
        tick();
        set_port(0, 1'b0, 6'd5, 1'b1, '0, '0);
        set_port(1, 1'b1, 6'd5, 1'b0, '0, '0);
        @(negedge clk);
        check("raw_rd_grant", req_ready[1], 1);
        tick();
        set_port(1, 1'b0, 6'd5, 1'b0, '0, '0);
        @(negedge clk);
        check("raw_wr_rsp_valid", rsp_valid[0], 1);
        check("raw_wr_rsp_data", rsp_rdata[63:0], 0);
        tick();
        @(negedge clk);
        check("raw_rd_rsp_valid", rsp_valid[1], 1);
        check("raw_rd_rsp_data", rsp_rdata[127:64], 64'h1122_3344_5566_7788);
        tick();

        // Both ports hammer bank 1 for four cycles.
        set_port(0, 1'b1, 6'd1, 1'b0, '0, '0);
        set_port(1, 1'b1, 6'd5, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_grant", req_ready, exp_seq[i]);
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        check("conflict_4", cnt, 4);
        tick();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        @(negedge clk);
        check("conflict_clr", cnt, 0);
        tick();

        // Different banks proceed in parallel.
        set_port(0, 1'b1, 6'd2, 1'b0, '0, '0);
        set_port(1, 1'b1, 6'd3, 1'b0, '0, '0);
        @(negedge clk);
        check("par_ready", req_ready, 2'b11);
        tick();
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("par_rsp_valid", rsp_valid, 2'b11);
        check("par_cnt", cnt, 0);
        tick();

        // Byte-enable merge.
        xfer(0, 6'd9, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 64'h0, "pw_full");
        xfer(0, 6'd9, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0, "pw_part");
        xfer(1, 6'd9, 1'b0, '0, '0, 64'hAAAA_AAAA_FFFF_FFFF, "pw_rd");

        // Fill started while a read is in flight, then aborted by reset at row 7.
        set_port(0, 1'b1, 6'd5, 1'b0, '0, '0);
        init_start = 1'b1;
        @(negedge clk);
        check("mid_grant", req_ready[0], 1);
        tick();
        req_valid = '0;
        init_start = 1'b0;
        @(negedge clk);
        check("mid_busy", init_busy, 1);
        @(negedge clk);
        check("mid_rsp_valid", rsp_valid[0], 1);
        check("mid_rsp_data", rsp_rdata[63:0], 64'h1122_3344_5566_7788);
        repeat (6) tick();
        rst_i = 1'b1;
        tick();
        @(negedge clk);
        check("abort_busy", init_busy, 0);
        tick();
        rst_i = 1'b0;
        count_busy(nbusy);
        check("reinit_len", nbusy, WPB);
        xfer(1, 6'd5, 1'b0, '0, '0, 64'h0, "post_init_rd");

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
